// File: rtl/alarm_pkg.sv
// Shared types, limits and time arithmetic helpers for the alarm mode controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_e;

  localparam logic [3:0] HR_MIN  = 4'd1;
  localparam logic [3:0] HR_MAX  = 4'd12;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Power-up / reset value of the editable registers: 12:00 AM.
  localparam logic [3:0] RST_HR  = 4'd12;
  localparam logic [5:0] RST_MIN = 6'd0;
  localparam logic       RST_PM  = 1'b0;

  // 12-hour clock: 12 wraps to 1, everything else counts up.
  function automatic logic [3:0] hr_inc(input logic [3:0] hr);
    logic [3:0] nxt;
    if (hr >= HR_MAX) begin
      nxt = HR_MIN;
    end else begin
      nxt = hr + 4'd1;
    end
    return nxt;
  endfunction

  // Minutes wrap 59 -> 0 with no carry into the hour.
  function automatic logic [5:0] min_inc(input logic [5:0] mn);
    logic [5:0] nxt;
    if (mn >= MIN_MAX) begin
      nxt = 6'd0;
    end else begin
      nxt = mn + 6'd1;
    end
    return nxt;
  endfunction

  // AM/PM flips when the hour steps from 11 to 12.
  function automatic logic pm_flips(input logic [3:0] hr);
    return (hr == (HR_MAX - 4'd1));
  endfunction

endpackage

// File: rtl/hm_setter.sv
// Editable hour/minute/PM register with increment strobes and a parallel load.
module hm_setter
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [3:0] ld_hr,
  input  logic [5:0] ld_min,
  input  logic       ld_pm,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [3:0] hr,
  output logic [5:0] min,
  output logic       pm
);

  logic [3:0] hr_d,  hr_q;
  logic [5:0] min_d, min_q;
  logic       pm_d,  pm_q;

  // Next register value: a load overrides, otherwise hour and minute steps apply independently.
  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    pm_d  = pm_q;
    if (load_en) begin
      hr_d  = ld_hr;
      min_d = ld_min;
      pm_d  = ld_pm;
    end else begin
      if (inc_hr) begin
        hr_d = hr_inc(hr_q);
        if (pm_flips(hr_q)) begin
          pm_d = ~pm_q;
        end else begin
          pm_d = pm_q;
        end
      end else begin
        hr_d = hr_q;
        pm_d = pm_q;
      end
      if (inc_min) begin
        min_d = min_inc(min_q);
      end else begin
        min_d = min_q;
      end
    end
  end

  // Register state, resetting to 12:00 AM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr_q  <= RST_HR;
      min_q <= RST_MIN;
      pm_q  <= RST_PM;
    end else begin
      hr_q  <= hr_d;
      min_q <= min_d;
      pm_q  <= pm_d;
    end
  end

  assign hr  = hr_q;
  assign min = min_q;
  assign pm  = pm_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: display mode FSM, set-time/alarm registers, alarm ringing.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_hr,
  input  logic       btn_min,
  input  logic       btn_off,
  input  logic       sec_tick,
  input  logic [3:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic       cur_pm,
  output logic       enable,
  output logic       enable_a,
  output logic [3:0] set_hr,
  output logic [5:0] set_min,
  output logic       set_pm,
  output logic       load,
  output logic [3:0] al_hr,
  output logic [5:0] al_min,
  output logic       al_pm,
  output logic       ringing
);

  localparam int CW = $clog2(RING_SECS + 1);

  mode_e         state_d, state_q;
  logic          enable_d, enable_q;
  logic          enable_a_d, enable_a_q;
  logic          load_d, load_q;
  logic          set_ld_s;
  logic          set_inc_hr_s, set_inc_min_s;
  logic          al_inc_hr_s, al_inc_min_s;
  logic          match_d, match_q;
  logic          match_dly_q;
  logic          trigger_s;
  logic          timeout_s;
  logic          ringing_d, ringing_q;
  logic [CW-1:0] cnt_d, cnt_q;

  // Mode sequencing; btn_mode wins over any increment pulse in the same cycle.
  always_comb begin
    state_d       = state_q;
    load_d        = 1'b0;
    set_ld_s      = 1'b0;
    set_inc_hr_s  = 1'b0;
    set_inc_min_s = 1'b0;
    al_inc_hr_s   = 1'b0;
    al_inc_min_s  = 1'b0;
    case (state_q)
      SHOW: begin
        if (btn_mode) begin
          state_d  = SET_TIME;
          set_ld_s = 1'b1;
        end else begin
          state_d  = SHOW;
        end
      end
      SET_TIME: begin
        if (btn_mode) begin
          state_d = SET_ALARM;
          load_d  = 1'b1;
        end else begin
          set_inc_hr_s  = btn_hr;
          set_inc_min_s = btn_min;
        end
      end
      SET_ALARM: begin
        if (btn_mode) begin
          state_d = SHOW;
        end else begin
          al_inc_hr_s  = btn_hr;
          al_inc_min_s = btn_min;
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase
    enable_d   = (state_d == SET_TIME);
    enable_a_d = (state_d == SET_ALARM);
  end

  // Mode FSM with its registered selects and load pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SHOW;
      enable_q   <= 1'b0;
      enable_a_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      enable_a_q <= enable_a_d;
      load_q     <= load_d;
    end
  end

  hm_setter u_set (
    .clk     (clk),
    .rst     (reset),
    .load_en (set_ld_s),
    .ld_hr   (cur_hr),
    .ld_min  (cur_min),
    .ld_pm   (cur_pm),
    .inc_hr  (set_inc_hr_s),
    .inc_min (set_inc_min_s),
    .hr      (set_hr),
    .min     (set_min),
    .pm      (set_pm)
  );

  hm_setter u_alarm (
    .clk     (clk),
    .rst     (reset),
    .load_en (1'b0),
    .ld_hr   (RST_HR),
    .ld_min  (RST_MIN),
    .ld_pm   (RST_PM),
    .inc_hr  (al_inc_hr_s),
    .inc_min (al_inc_min_s),
    .hr      (al_hr),
    .min     (al_min),
    .pm      (al_pm)
  );

  // Match detection, rising-edge trigger and ring timeout; a new trigger restarts the count.
  always_comb begin
    match_d   = (state_q == SHOW) &&
                (cur_hr == al_hr) && (cur_min == al_min) && (cur_pm == al_pm);
    trigger_s = match_q & ~match_dly_q;
    timeout_s = ringing_q && sec_tick && (cnt_q == CW'(RING_SECS - 1));
    if (btn_off) begin
      ringing_d = 1'b0;
    end else if (trigger_s) begin
      ringing_d = 1'b1;
    end else if (timeout_s) begin
      ringing_d = 1'b0;
    end else begin
      ringing_d = ringing_q;
    end
    if (!ringing_d || !ringing_q || trigger_s) begin
      cnt_d = '0;
    end else if (sec_tick) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match pipeline, ringing flag and tick counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q     <= 1'b0;
      match_dly_q <= 1'b0;
      ringing_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      match_q     <= match_d;
      match_dly_q <= match_q;
      ringing_q   <= ringing_d;
      cnt_q       <= cnt_d;
    end
  end

  assign enable   = enable_q;
  assign enable_a = enable_a_q;
  assign load     = load_q;
  assign ringing  = ringing_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Self-checking bench for alarm_mode_ctrl: directed scenarios then randomized traffic,
// compared against a minutes-of-day reference model.
module tb_alarm_mode_ctrl;

  localparam int RS = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_hr, btn_min, btn_off, sec_tick;
  logic [3:0] cur_hr;
  logic [5:0] cur_min;
  logic       cur_pm;
  logic       enable, enable_a, load, ringing;
  logic [3:0] set_hr, al_hr;
  logic [5:0] set_min, al_min;
  logic       set_pm, al_pm;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0/1/2 = show/set-time/set-alarm, times as minutes since midnight.
  int m_mode, m_set, m_al, m_ticks;
  bit m_load, m_match, m_match_old, m_ring;

  alarm_mode_ctrl #(.RING_SECS(RS)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_hr(btn_hr), .btn_min(btn_min),
    .btn_off(btn_off), .sec_tick(sec_tick), .cur_hr(cur_hr), .cur_min(cur_min),
    .cur_pm(cur_pm), .enable(enable), .enable_a(enable_a), .set_hr(set_hr),
    .set_min(set_min), .set_pm(set_pm), .load(load), .al_hr(al_hr), .al_min(al_min),
    .al_pm(al_pm), .ringing(ringing)
  );

  always #5 clk = ~clk;

  function automatic int to_mod(int hr, int mn, int pm);
    return ((hr % 12) + (pm != 0 ? 12 : 0)) * 60 + mn;
  endfunction
  function automatic int hr_of(int t);
    int h;
    h = (t / 60) % 12;
    return (h == 0) ? 12 : h;
  endfunction
  function automatic int min_of(int t);
    return t % 60;
  endfunction
  function automatic int pm_of(int t);
    return (t >= 720) ? 1 : 0;
  endfunction
  // One hour later on the wall clock; AM/PM falls out of the day arithmetic.
  function automatic int plus_hour(int t);
    return (t + 60) % 1440;
  endfunction
  function automatic int plus_minute(int t);
    return t - (t % 60) + ((t % 60) + 1) % 60;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".enable"},   int'(enable),   int'(m_mode == 1));
    check({tag, ".enable_a"}, int'(enable_a), int'(m_mode == 2));
    check({tag, ".load"},     int'(load),     int'(m_load));
    check({tag, ".set_hr"},   int'(set_hr),   hr_of(m_set));
    check({tag, ".set_min"},  int'(set_min),  min_of(m_set));
    check({tag, ".set_pm"},   int'(set_pm),   pm_of(m_set));
    check({tag, ".al_hr"},    int'(al_hr),    hr_of(m_al));
    check({tag, ".al_min"},   int'(al_min),   min_of(m_al));
    check({tag, ".al_pm"},    int'(al_pm),    pm_of(m_al));
    check({tag, ".ringing"},  int'(ringing),  int'(m_ring));
  endtask

  task automatic model_reset();
    m_mode = 0; m_set = 0; m_al = 0; m_ticks = 0;
    m_load = 0; m_match = 0; m_match_old = 0; m_ring = 0;
  endtask

  task automatic set_cur(input int hr, input int mn, input int pm);
    cur_hr = 4'(hr); cur_min = 6'(mn); cur_pm = 1'(pm);
  endtask

  // Apply one cycle of button/tick pulses, advance the model, and compare after the edge.
  task automatic step(input string tag, input bit bm, input bit bh, input bit bn,
                      input bit bo, input bit tk);
    int  cur_t;
    bit  rise;
    btn_mode = bm; btn_hr = bh; btn_min = bn; btn_off = bo; sec_tick = tk;
    cur_t = to_mod(int'(cur_hr), int'(cur_min), int'(cur_pm));
    rise  = m_match && !m_match_old;
    if (bo) begin
      m_ring = 0; m_ticks = 0;
    end else if (rise) begin
      m_ring = 1; m_ticks = 0;
    end else if (m_ring && tk) begin
      m_ticks++;
      if (m_ticks == RS) begin
        m_ring = 0; m_ticks = 0;
      end
    end
    m_match_old = m_match;
    m_match     = (m_mode == 0) && (cur_t == m_al);
    m_load      = bm && (m_mode == 1);
    if (bm) begin
      if (m_mode == 0) m_set = cur_t;
      m_mode = (m_mode + 1) % 3;
    end else if (m_mode == 1) begin
      if (bh) m_set = plus_hour(m_set);
      if (bn) m_set = plus_minute(m_set);
    end else if (m_mode == 2) begin
      if (bh) m_al = plus_hour(m_al);
      if (bn) m_al = plus_minute(m_al);
    end
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_hr = 1'b0; btn_min = 1'b0; btn_off = 1'b0; sec_tick = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0; btn_hr = 1'b0; btn_min = 1'b0; btn_off = 1'b0; sec_tick = 1'b0;
    set_cur(12, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.al_hr_12", int'(al_hr), 12);
    @(negedge clk);
    reset = 1'b0;

    // Enter time-set from 03:15 PM, then commit with a load pulse.
    set_cur(3, 15, 1);
    step("to_set_time", 1, 0, 0, 0, 0);
    check("tset.hr", int'(set_hr), 3);
    check("tset.min", int'(set_min), 15);
    check("tset.pm", int'(set_pm), 1);
    step("to_set_alarm", 1, 0, 0, 0, 0);
    check("load.pulse", int'(load), 1);
    step("load_drop", 0, 0, 0, 0, 0);
    check("load.single", int'(load), 0);

    // Hour wrap: 10:59 AM -> 11 AM -> 12 PM -> 1 PM, then minute wrap with no carry.
    step("to_show", 1, 0, 0, 0, 0);
    set_cur(10, 59, 0);
    step("to_set_time2", 1, 0, 0, 0, 0);
    step("hr11", 0, 1, 0, 0, 0);
    check("wrap.h11", int'(set_hr), 11);
    check("wrap.am11", int'(set_pm), 0);
    step("hr12", 0, 1, 0, 0, 0);
    check("wrap.h12", int'(set_hr), 12);
    check("wrap.pm12", int'(set_pm), 1);
    step("hr1", 0, 1, 0, 0, 0);
    check("wrap.h1", int'(set_hr), 1);
    check("wrap.pm1", int'(set_pm), 1);
    step("min_wrap", 0, 0, 1, 0, 0);
    check("wrap.min0", int'(set_min), 0);
    check("wrap.hr_kept", int'(set_hr), 1);
    step("both_inc", 0, 1, 1, 0, 0);

    // Mode beats a coincident hour press.
    step("prio", 1, 1, 0, 0, 0);
    check("prio.enable_a", int'(enable_a), 1);
    check("prio.hr_kept", int'(set_hr), 2);

    // Alarm to 7:00 AM from 12:00 AM.
    for (int i = 0; i < 7; i++) step("al_hr", 0, 1, 0, 0, 0);
    check("alarm.hr7", int'(al_hr), 7);
    check("alarm.am", int'(al_pm), 0);
    step("al_to_show", 1, 0, 0, 0, 0);
    set_cur(7, 0, 0);
    step("match_reg", 0, 0, 0, 0, 0);
    check("ring.not_yet", int'(ringing), 0);
    step("ring_on", 0, 0, 0, 0, 0);
    check("ring.on", int'(ringing), 1);
    for (int i = 0; i < RS - 1; i++) step("ring_hold", 0, 0, 0, 0, 1);
    check("ring.held", int'(ringing), 1);
    step("ring_last_tick", 0, 0, 0, 0, 1);
    check("ring.auto_off", int'(ringing), 0);
    for (int i = 0; i < 5; i++) step("no_retrigger", 0, 0, 0, 0, 1);
    check("ring.no_retrigger", int'(ringing), 0);

    // Re-arm, change modes while ringing, then silence.
    set_cur(7, 1, 0);
    step("rearm_off", 0, 0, 0, 0, 0);
    set_cur(7, 0, 0);
    step("rearm_match", 0, 0, 0, 0, 0);
    step("rearm_ring", 0, 0, 0, 0, 0);
    check("ring.rearmed", int'(ringing), 1);
    step("ring_mode", 1, 0, 0, 0, 0);
    check("ring.persist", int'(ringing), 1);
    step("ring_off", 0, 0, 0, 1, 0);
    check("ring.silenced", int'(ringing), 0);

    // Reset in the middle of editing the alarm.
    step("to_set_alarm3", 1, 0, 0, 0, 0);
    step("al_edit", 0, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midreset");
    check("midreset.al_hr", int'(al_hr), 12);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midreset.load", int'(load), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 0, 0, 0, 0, 0);
    check("post_reset.show", int'(enable) + int'(enable_a), 0);

    // Randomized traffic, with the running time frequently steered onto the alarm.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        set_cur(hr_of(m_al), min_of(m_al), pm_of(m_al));
      end else if (r == 1) begin
        set_cur(int'($urandom_range(1, 12)), int'($urandom_range(0, 59)),
                int'($urandom_range(0, 1)));
      end
      step("rand",
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Mode controller for the alarm clock. Sequences the display between running time, time-set and alarm-set modes and drives the `enable`/`enable_a` selects consumed by the PM-flag mux. Owns the editable set-time and alarm registers, issues a one-cycle load to the timekeeper, and raises the alarm on a time match.

## Interface

**Parameters**
- `RING_SECS`, default 60: ring duration in `sec_tick` pulses before auto-silence.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `btn_mode` in 1: debounced one-cycle pulse; advances the mode.
- `btn_hr` in 1: one-cycle pulse; increments the hour of the register being edited.
- `btn_min` in 1: one-cycle pulse; increments the minute of the register being edited.
- `btn_off` in 1: one-cycle pulse; silences the alarm.
- `sec_tick` in 1: one-cycle pulse, once per second.
- `cur_hr` in 4: running hour, 1–12.
- `cur_min` in 6: running minute, 0–59.
- `cur_pm` in 1: running PM flag.
- `enable` out 1: 1 only in SET_TIME.
- `enable_a` out 1: 1 only in SET_ALARM.
- `set_hr` out 4, `set_min` out 6, `set_pm` out 1: time-set register.
- `load` out 1: one-cycle pulse that commits `set_*` to the timekeeper.
- `al_hr` out 4, `al_min` out 6, `al_pm` out 1: alarm register.
- `ringing` out 1: alarm active.

## Operation

- **States:**
  - SHOW: `enable=0`, `enable_a=0`.
  - SET_TIME: `enable=1`, `enable_a=0`.
  - SET_ALARM: `enable=0`, `enable_a=1`.
- **Transitions on `btn_mode`:**
  - SHOW→SET_TIME: `set_*` are loaded from `cur_*` in that cycle.
  - SET_TIME→SET_ALARM: `load` pulses.
  - SET_ALARM→SHOW.
- **Increment routing:** `btn_hr`/`btn_min` act on `set_*` in SET_TIME and on `al_*` in SET_ALARM. They are ignored in SHOW.
- **Hour increment:**
  - 1..11 → +1.
  - 11→12 toggles the PM flag.
  - 12→1 leaves the PM flag unchanged.
- **Minute increment:** 59→0 with no hour carry.
- **Simultaneous pulses:** `btn_mode` takes priority over `btn_hr`/`btn_min`; a coincident increment is dropped. `btn_hr` and `btn_min` in the same cycle both apply.
- **Match:** `match = (cur_* == al_*)`, evaluated only in SHOW, registered as `match_q`.
- **Ringing start:** `ringing` sets on the rising edge of `match_q`, so a match lasting 60 s triggers once.
- **Ringing clear:** `btn_off`, or `RING_SECS` `sec_tick` pulses counted after ringing set. The counter is `$clog2(RING_SECS+1)` bits and is cleared whenever `ringing=0`.
- **Ringing across mode changes:** `ringing` persists across mode changes; only `btn_off` or the timeout clears it. `btn_off` in the same cycle as a new trigger leaves `ringing=0`.

## Timing

- All outputs are registered.
- **Reset values:**
  - State is SHOW; `enable=0`, `enable_a=0`, `load=0`, `ringing=0`.
  - `set_*` and `al_*` are 12:00 AM (`hr=12`, `min=0`, `pm=0`).
  - `match_q=0`; ring counter 0.
- **Mode change latency:** `btn_mode` sampled at edge N → new `enable`/`enable_a` visible after edge N.
- **Load:** `load` is high for exactly the cycle after edge N, coincident with `enable` falling.
- **Increment latency:** `btn_hr`/`btn_min` at edge N → register updated after edge N.
- **Ringing latency:** match true at edge N → `match_q` at N → `ringing=1` after edge N+1.
- **Auto-silence:** `ringing` falls after the edge sampling the `RING_SECS`-th tick.
- **Reset mid-operation:** a reset while in a set mode discards edits, does not pulse `load`, and returns to SHOW.

## Structure

- **Package `alarm_pkg`:**
  - Mode enum (SHOW, SET_TIME, SET_ALARM).
  - `HR_MIN=1`, `HR_MAX=12`, `MIN_MAX=59`.
  - Reset-time constants.
- **Sub-module `hm_setter`:** hour/minute/pm register with increment and load-from-input. Instantiated twice, once for `set_*` and once for `al_*`.
- **Top level:** the FSM, match/ring logic and the ring counter.

## Test plan

- **Reset and time-set load:** reset, then `btn_mode` with `cur`=03:15 PM → `enable=1`, `set`=03:15 PM. Then `btn_mode` → one-cycle `load`, `enable_a=1`, `enable=0`.
- **Hour wrap:** in SET_TIME from 10:59 AM, three `btn_hr` → 11 AM, 12 PM, 1 PM. Then `btn_min` → minute 0 with hour unchanged.
- **Alarm set and trigger:** in SET_ALARM, raise alarm to 7:00 AM. Return to SHOW, drive `cur`=07:00 AM → `ringing=1` two cycles later. Hold `cur` for 60 ticks → auto-clear after `RING_SECS`=60 ticks, no retrigger.
- **Manual silence and persistence:** while ringing, `btn_mode` → `ringing` stays 1. Then `btn_off` → `ringing=0` next cycle.
- **Priority:** `btn_mode` together with `btn_hr` in SET_TIME → state advances, hour unchanged.
- **Reset mid-edit:** assert reset while in SET_ALARM → SHOW, `al`=12:00 AM, `load` never pulses.
